// File: rtl/if_prefetch_stage.sv
// -----------------------------------------------------------------------------
// if_prefetch_stage
// Instruction-fetch prefetch stage. Streams sequential word addresses to the
// instruction memory and buffers the returned instructions in a small FIFO
// that decode consumes from the head.
//
// Ports
//   clk                 single clock, all state on the rising edge
//   rst                 asynchronous active-high reset
//   hazard_detected_in  decode freeze: head held, no pop (prefetch continues)
//   br_taken            redirect: flush queue, drop in-flight data, refetch
//   br_target           redirect word address
//   imem_req/imem_addr  fetch request and its word address (combinational)
//   imem_ready          memory accepts the request this cycle
//   imem_rdata          instruction, valid one cycle after acceptance
//   if_valid            queue head holds an instruction
//   if_instr/if_pc      head instruction and its word address (zero if empty)
//   if_pc_plus1         if_pc + 1 modulo 2^16
// -----------------------------------------------------------------------------
module if_prefetch_stage #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_detected_in,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus1
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Queue storage is pure data and carries no reset; r_count gates its use.
    logic [15:0]   r_instr_q [DEPTH];
    logic [15:0]   r_pc_q    [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [15:0]   r_fetch_pc;

    // Request stage -> response stage: one outstanding request at most.
    logic          vld_p1;
    logic [15:0]   r_inflight_pc_p1;

    logic [CW:0]   w_used;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return p + PW'(1);
    endfunction

    // Credits: queued entries plus the outstanding response must leave room,
    // so every accepted request is guaranteed a slot when its data returns.
    assign w_used    = {1'b0, r_count} + {{CW{1'b0}}, vld_p1};
    assign imem_req  = !rst && !br_taken && (w_used < (CW+1)'(DEPTH));
    assign imem_addr = r_fetch_pc;
    assign w_accept  = imem_req && imem_ready;

    // A redirect discards the response arriving in the same cycle.
    assign w_push    = vld_p1 && !br_taken;
    assign w_pop     = if_valid && !hazard_detected_in && !br_taken;

    assign if_valid    = (r_count != '0);
    assign if_instr    = if_valid ? r_instr_q[r_head] : 16'h0000;
    assign if_pc       = if_valid ? r_pc_q[r_head]    : 16'h0000;
    assign if_pc_plus1 = if_pc + 16'd1;

    // ---- control: fetch pointer, outstanding flag, queue pointers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            vld_p1     <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (br_taken) begin
            r_fetch_pc <= br_target;
            vld_p1     <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            vld_p1 <= w_accept;
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 16'd1;
            end
            if (w_push) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // ---- data: address of the outstanding request, queue payload ----
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_inflight_pc_p1 <= r_fetch_pc;
        end
        if (w_push) begin
            r_instr_q[r_tail] <= imem_rdata;
            r_pc_q[r_tail]    <= r_inflight_pc_p1;
        end
    end

endmodule

// File: tb/tb_if_prefetch_stage.sv
module tb_if_prefetch_stage;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard_detected_in;
    logic        br_taken;
    logic [15:0] br_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus1;

    // Second instance with a reset address just below the wrap point.
    logic        w_req;
    logic [15:0] w_addr;
    logic [15:0] w_rdata;
    logic        w_valid;
    logic [15:0] w_instr;
    logic [15:0] w_pc;
    logic [15:0] w_pc_plus1;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: list of buffered pcs, one outstanding fetch, fetch pc.
    logic [15:0] mq[$];
    bit          m_infl;
    logic [15:0] m_infl_pc;
    logic [15:0] m_fpc;
    bit          model_on = 1'b0;

    always #5 clk = ~clk;

    if_prefetch_stage #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .hazard_detected_in(hazard_detected_in),
        .br_taken(br_taken), .br_target(br_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .if_pc_plus1(if_pc_plus1)
    );

    if_prefetch_stage #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) u_wrap (
        .clk(clk), .rst(rst), .hazard_detected_in(hazard_detected_in),
        .br_taken(br_taken), .br_target(br_target),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready),
        .imem_rdata(w_rdata), .if_valid(w_valid), .if_instr(w_instr),
        .if_pc(w_pc), .if_pc_plus1(w_pc_plus1)
    );

    // Simple memory for the wrap instance: returns addr^A000 one cycle later.
    always @(posedge clk) begin
        w_rdata <= (w_req && imem_ready) ? (w_addr ^ 16'hA000) : 16'h5A5A;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit exp_req();
        return !rst && !br_taken && ((mq.size() + int'(m_infl)) < DEPTH);
    endfunction

    task automatic model_clear();
        mq.delete();
        m_infl = 1'b0;
        m_fpc  = 16'h0000;
    endtask

    // Advance the model across one rising edge using the inputs just applied.
    task automatic model_edge();
        bit req;
        req = exp_req();
        if (br_taken) begin
            mq.delete();
            m_infl = 1'b0;
            m_fpc  = br_target;
        end else begin
            if (mq.size() > 0 && !hazard_detected_in) void'(mq.pop_front());
            if (m_infl) mq.push_back(m_infl_pc);
            m_infl = req && imem_ready;
            if (m_infl) begin
                m_infl_pc = m_fpc;
                m_fpc     = m_fpc + 16'd1;
            end
        end
    endtask

    // Called at posedge+1: apply inputs, memory answers the outstanding fetch.
    task automatic drive(input bit br, input logic [15:0] tgt, input bit hz, input bit rdy);
        br_taken           = br;
        br_target          = tgt;
        hazard_detected_in = hz;
        imem_ready         = rdy;
        imem_rdata         = m_infl ? (m_infl_pc ^ 16'hA000) : 16'($urandom);
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset(input int ncyc);
        #2;
        rst = 1'b1;
        model_clear();
        repeat (ncyc) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Compare process: every output against the model on every falling edge.
    always @(negedge clk) begin
        if (model_on) begin
            logic [15:0] ep;
            ep = (mq.size() > 0) ? mq[0] : 16'h0000;
            check("imem_req",    {31'b0, imem_req}, {31'b0, exp_req()});
            check("imem_addr",   {16'b0, imem_addr}, {16'b0, m_fpc});
            check("if_valid",    {31'b0, if_valid}, {31'b0, (mq.size() > 0)});
            check("if_pc",       {16'b0, if_pc}, {16'b0, ep});
            check("if_instr",    {16'b0, if_instr}, (mq.size() > 0) ? {16'b0, ep ^ 16'hA000} : 32'h0);
            check("if_pc_plus1", {16'b0, if_pc_plus1}, {16'b0, ep + 16'd1});
        end
    end

    initial begin
        rst = 1'b1;
        hazard_detected_in = 1'b0;
        br_taken   = 1'b0;
        br_target  = 16'h0000;
        imem_ready = 1'b1;
        imem_rdata = 16'h0000;
        model_clear();
        model_on = 1'b1;
        repeat (2) @(posedge clk);
        #4;
        check("rst_if_valid",    {31'b0, if_valid}, 32'h0);
        check("rst_imem_req",    {31'b0, imem_req}, 32'h0);
        check("rst_if_pc",       {16'b0, if_pc}, 32'h0);
        check("rst_if_pc_plus1", {16'b0, if_pc_plus1}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming, then a 10-cycle freeze with pc 3 at the head.
        for (int k = 0; k < 19; k++) begin
            drive(1'b0, 16'h0000, (k >= 5 && k <= 14), 1'b1);
            if (k == 0) begin
                check("s_first_req",  {31'b0, imem_req}, 32'h1);
                check("s_first_addr", {16'b0, imem_addr}, 32'h0);
                check("s_no_bypass",  {31'b0, if_valid}, 32'h0);
            end
            if (k >= 2 && k <= 5) begin
                check("s_pc",    {16'b0, if_pc}, k - 2);
                check("s_instr", {16'b0, if_instr}, (k - 2) ^ 32'hA000);
            end
            if (k == 2) check("w_pc0", {16'b0, w_pc}, 32'hFFFE);
            if (k == 3) begin
                check("w_pc1",    {16'b0, w_pc}, 32'hFFFF);
                check("w_plus1",  {16'b0, w_pc_plus1}, 32'h0000);
            end
            if (k == 4) check("w_pc2", {16'b0, w_pc}, 32'h0000);
            if (k == 14) begin
                check("fz_pc",    {16'b0, if_pc}, 32'h3);
                check("fz_req",   {31'b0, imem_req}, 32'h0);
                check("fz_valid", {31'b0, if_valid}, 32'h1);
            end
            if (k >= 15) begin
                check("fz_rel_pc",    {16'b0, if_pc}, k - 12);
                check("fz_rel_valid", {31'b0, if_valid}, 32'h1);
            end
            tick();
        end

        // Redirect with the fetch of pc 5 outstanding; later redirect+hazard.
        do_reset(2);
        for (int k = 0; k < 15; k++) begin
            if (k == 6)       drive(1'b1, 16'h0040, 1'b0, 1'b1);
            else if (k == 12) drive(1'b1, 16'h0100, 1'b1, 1'b1);
            else              drive(1'b0, 16'h0000, 1'b0, 1'b1);
            if (k == 6) begin
                check("br_head_pc", {16'b0, if_pc}, 32'h4);
                check("br_sup_req", {31'b0, imem_req}, 32'h0);
            end
            if (k == 7) begin
                check("br_flush",   {31'b0, if_valid}, 32'h0);
                check("br_req",     {31'b0, imem_req}, 32'h1);
                check("br_addr",    {16'b0, imem_addr}, 32'h0040);
            end
            if (k == 9)  check("br_new_pc",  {16'b0, if_pc}, 32'h0040);
            if (k == 10) check("br_next_pc", {16'b0, if_pc}, 32'h0041);
            if (k == 13) begin
                check("brhz_flush", {31'b0, if_valid}, 32'h0);
                check("brhz_addr",  {16'b0, imem_addr}, 32'h0100);
            end
            tick();
        end

        // Randomized traffic with occasional redirects and mid-stream resets.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(int'($urandom_range(1, 2)));
            end else begin
                bit          br;
                logic [15:0] tgt;
                br  = ($urandom_range(0, 19) == 0);
                tgt = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                                  : 16'($urandom);
                drive(br, tgt, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_prefetch_stage.md
IF_PREFETCH_STAGE -- requirements
Module: if_prefetch_stage

Interface
REQ-001 SHALL have parameter DEPTH, 4, prefetch queue entries (power of two, 2..8).
REQ-002 SHALL have parameter RESET_PC, 16'h0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port hazard_detected_in  input  1  decode freeze; head entry held, no pop.
REQ-006 SHALL have port br_taken  input  1  redirect request from decode.
REQ-007 SHALL have port br_target  input  16  redirect word address.
REQ-008 SHALL have port imem_req  output  1  fetch request valid.
REQ-009 SHALL have port imem_addr  output  16  fetch word address.
REQ-010 SHALL have port imem_ready  input  1  memory accepts request this cycle.
REQ-011 SHALL have port imem_rdata  input  16  instruction, valid exactly 1 cycle after accepted request.
REQ-012 SHALL have port if_valid  output  1  queue head holds an instruction.
REQ-013 SHALL have port if_instr  output  16  head instruction (opcode [15:12]).
REQ-014 SHALL have port if_pc  output  16  word address of head instruction.
REQ-015 SHALL have port if_pc_plus1  output  16  if_pc+1, modulo 2^16.

Function
REQ-016 SHALL hold fetch_pc; request accepted when imem_req && imem_ready; fetch_pc increments by 1 per acceptance, wrapping 16'hFFFF -> 16'h0000.
REQ-017 SHALL drive imem_req=1 only when occupancy + in-flight < DEPTH and br_taken=0; imem_addr=fetch_pc, combinational.
REQ-018 SHALL track at most one in-flight response (1-cycle latency) with its address; response pushed to tail the cycle imem_rdata is valid.
REQ-019 SHALL count credits so an accepted request always finds a free slot; no overflow, no dropped response.
REQ-020 SHALL present head combinationally from registered storage; if_instr/if_pc undefined-free (zero) when if_valid=0.
REQ-021 SHALL pop head on a cycle with if_valid=1 and hazard_detected_in=0 and br_taken=0.
REQ-022 SHALL, when push and pop coincide, keep occupancy unchanged; push into empty queue visible on if_valid the next cycle (no bypass).
REQ-023 SHALL, on br_taken=1: empty queue next cycle, discard any in-flight response arriving next cycle, load fetch_pc<=br_target, suppress imem_req that cycle.
REQ-024 SHALL give br_taken priority over hazard_detected_in, push and pop in the same cycle.
REQ-025 SHALL issue first post-redirect request to br_target the cycle after br_taken.
REQ-026 SHALL stall requests (imem_req held, addr stable) while imem_ready=0; fetch_pc unchanged.
REQ-027 SHALL, while hazard_detected_in=1, continue prefetching until queue full, holding head outputs stable.

Reset
REQ-028 SHALL, on rst=1 (any cycle, mid-request or mid-redirect), immediately clear queue, in-flight flag and credits; fetch_pc=RESET_PC.
REQ-029 SHALL drive during reset: imem_req=0, if_valid=0, if_instr=0, if_pc=0, if_pc_plus1=1.
REQ-030 SHALL ignore imem_rdata in the first cycle after reset release; first request to RESET_PC that cycle.

Verification
REQ-031 SHALL cover streaming: imem_ready=1, no hazard, rdata=addr^16'hA000 -> if_valid from cycle 2, if_pc 0,1,2,... one per cycle, if_instr matching.
REQ-032 SHALL cover freeze: hazard_detected_in=1 for 10 cycles at if_pc=3 -> if_pc held 3, exactly DEPTH entries buffered, imem_req=0 when full; release -> pcs 3,4,5,6 back-to-back.
REQ-033 SHALL cover redirect with in-flight response: br_taken=1, br_target=16'h0040 while request to 5 outstanding -> if_valid=0 next cycle, instruction from 5 never appears, next if_pc=16'h0040.
REQ-034 SHALL cover simultaneous br_taken and hazard_detected_in=1 -> redirect wins, queue flushed.
REQ-035 SHALL cover wrap: RESET_PC=16'hFFFE -> if_pc FFFE, FFFF, 0000; if_pc_plus1 at FFFF = 0000.
REQ-036 SHALL cover imem_ready random 50% plus async rst asserted mid-stream -> no lost/duplicated/out-of-order pcs; outputs at reset values during rst.
